slave_out_port: RTL

SLAVE_OUT_PORT -- requirements
Module: slave_out_port

---
 rtl/slave_out_port_pkg.sv | 22 ++
 rtl/slave_out_port_bit_serializer.sv | 58 +++++
 rtl/slave_out_port.sv | 132 +++++++++++++
 3 files changed

// File: rtl/slave_out_port_pkg.sv
// Shared bus definitions for the master/slave port modules: default widths
// and the port FSM state encoding.
package slave_out_port_pkg;

  localparam int DEF_DATA_LEN  = 8;
  localparam int DEF_BURST_LEN = 12;
  localparam int DEF_ADDR_LEN  = 12;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FETCH     = 3'd1,
    HANDSHAKE = 3'd2,
    SEND      = 3'd3,
    DONE      = 3'd4
  } state_t;

  // Slot counter must reach DATA_LEN, one beyond the last data bit.
  function automatic int slot_width(input int data_len);
    return $clog2(data_len + 1);
  endfunction

endpackage

// File: rtl/slave_out_port_bit_serializer.sv
// LSB-first word serializer: DATA_LEN+1 slots per word, last slot repeats the MSB.
module bit_serializer
  import slave_out_port_pkg::*;
#(
  parameter int DATA_LEN = DEF_DATA_LEN,
  parameter int SLOT_W   = slot_width(DATA_LEN)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clear,
  input  logic                load,
  input  logic                start,
  input  logic                reload,
  input  logic                shift,
  input  logic [DATA_LEN-1:0] load_data,
  input  logic [DATA_LEN-1:0] reload_data,
  output logic                tx_data,
  output logic                last_slot,
  output logic [SLOT_W-1:0]   slot
);

  logic [DATA_LEN-1:0] sr;

  // Arithmetic right shift: once the MSB reaches bit 0 it stays there,
  // which gives the repeated MSB in the final slot for free.
  function automatic logic [DATA_LEN-1:0] asr(input logic [DATA_LEN-1:0] x);
    return {x[DATA_LEN-1], x[DATA_LEN-1:1]};
  endfunction

  assign last_slot = (slot == SLOT_W'(DATA_LEN));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sr      <= '0;
      slot    <= '0;
      tx_data <= 1'b0;
    end else if (clear) begin
      sr      <= '0;
      slot    <= '0;
      tx_data <= 1'b0;
    end else if (load) begin
      sr <= load_data;
    end else if (start) begin
      tx_data <= sr[0];
      sr      <= asr(sr);
      slot    <= '0;
    end else if (reload) begin
      tx_data <= reload_data[0];
      sr      <= asr(reload_data);
      slot    <= '0;
    end else if (shift) begin
      tx_data <= sr[0];
      sr      <= asr(sr);
      slot    <= slot + SLOT_W'(1);
    end
  end

endmodule

// File: rtl/slave_out_port.sv
// Slave output port: fetches a burst of words from slave memory and streams
// them serially to the master after a single valid/ready handshake.
//
// state     | meaning
// IDLE      | waiting for read_en; first read strobe issued combinationally
// FETCH     | first word arriving on mem_rdata, loaded into serializer
// HANDSHAKE | slave_valid held until master_ready
// SEND      | streaming slots; prefetching the next word in slots 0/1
// DONE      | one-cycle tx_done pulse, then back to IDLE
module slave_out_port
  import slave_out_port_pkg::*;
#(
  parameter int DATA_LEN  = DEF_DATA_LEN,
  parameter int BURST_LEN = DEF_BURST_LEN,
  parameter int ADDR_LEN  = DEF_ADDR_LEN
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 read_en,
  input  logic [ADDR_LEN-1:0]  start_addr,
  input  logic [BURST_LEN-1:0] burst_num,
  input  logic [DATA_LEN-1:0]  mem_rdata,
  input  logic                 master_ready,
  output logic                 mem_rd,
  output logic [ADDR_LEN-1:0]  mem_addr,
  output logic                 slave_valid,
  output logic                 tx_data,
  output logic                 tx_done,
  output logic                 busy
);

  localparam int SLOT_W = slot_width(DATA_LEN);

  state_t               state;
  logic [ADDR_LEN-1:0]  addr_q;
  logic [BURST_LEN-1:0] words_left;
  logic [DATA_LEN-1:0]  next_buf;
  logic                 mem_rd_q;
  logic                 accept;
  logic                 last_slot;
  logic [SLOT_W-1:0]    slot;
  logic                 more;

  // The first read must leave in the read_en cycle so the word is back by
  // the end of FETCH; every later strobe is registered.
  assign accept   = reset && (state == IDLE) && read_en;
  assign mem_rd   = mem_rd_q | accept;
  assign mem_addr = accept ? start_addr : addr_q;
  assign more     = (words_left != '0);

  bit_serializer #(
    .DATA_LEN (DATA_LEN),
    .SLOT_W   (SLOT_W)
  ) u_ser (
    .clk         (clk),
    .reset       (reset),
    .clear       ((state == SEND) && last_slot && !more),
    .load        (state == FETCH),
    .start       ((state == HANDSHAKE) && master_ready),
    .reload      ((state == SEND) && last_slot && more),
    .shift       ((state == SEND) && !last_slot),
    .load_data   (mem_rdata),
    .reload_data (next_buf),
    .tx_data     (tx_data),
    .last_slot   (last_slot),
    .slot        (slot)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      addr_q      <= '0;
      words_left  <= '0;
      next_buf    <= '0;
      mem_rd_q    <= 1'b0;
      slave_valid <= 1'b0;
      tx_done     <= 1'b0;
      busy        <= 1'b0;
    end else begin
      mem_rd_q <= 1'b0;
      case (state)
        IDLE: begin
          if (read_en) begin
            addr_q     <= start_addr;
            words_left <= burst_num;
            busy       <= 1'b1;
            state      <= FETCH;
          end
        end
        FETCH: begin
          slave_valid <= 1'b1;
          state       <= HANDSHAKE;
        end
        HANDSHAKE: begin
          if (master_ready) begin
            slave_valid <= 1'b0;
            state       <= SEND;
            if (more) begin
              mem_rd_q <= 1'b1;
              addr_q   <= addr_q + ADDR_LEN'(1);
            end
          end
        end
        SEND: begin
          if ((slot == SLOT_W'(1)) && more)
            next_buf <= mem_rdata;
          if (last_slot) begin
            if (more) begin
              words_left <= words_left - BURST_LEN'(1);
              if (words_left != BURST_LEN'(1)) begin
                mem_rd_q <= 1'b1;
                addr_q   <= addr_q + ADDR_LEN'(1);
              end
            end else begin
              tx_done <= 1'b1;
              state   <= DONE;
            end
          end
        end
        DONE: begin
          tx_done  <= 1'b0;
          busy     <= 1'b0;
          addr_q   <= '0;
          next_buf <= '0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
